uart_rx_cfg: RTL and testbench

UART_RX_CFG -- requirements
Module: uart_rx_cfg

---
 rtl/uart_pkg.sv | 16 +
 rtl/uart_sync2.sv | 26 ++
 rtl/uart_rx_cfg.sv | 175 +++++++++++++++++
 tb/tb_uart_rx_cfg.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the configurable UART receiver: FSM states and parity modes.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PAR,
    STOP
  } uart_state_e;

  localparam int PAR_NONE = 0;
  localparam int PAR_EVEN = 1;
  localparam int PAR_ODD  = 2;

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchronizer for an asynchronous single-bit input.
module uart_sync2 #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_meta <= RST_VAL;
      r_sync <= RST_VAL;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/uart_rx_cfg.sv
// UART receiver with configurable data width, parity and stop bits; holds one
// received word with its error flags until the consumer takes it.
module uart_rx_cfg
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 valid,
  input  logic                 ready,
  output logic                 busy,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 overrun
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int BW = $clog2(DATA_BITS + 1);

  localparam logic [CW-1:0] CNT_HALF  = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] CNT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);
  localparam logic [BW-1:0] STOP_LAST = BW'(STOP_BITS - 1);

  logic w_rxs;

  uart_sync2 #(.RST_VAL(1'b1)) u_sync (
    .clk (clk),
    .rst (rst),
    .i_d (rx),
    .o_q (w_rxs)
  );

  uart_state_e          r_state, w_state_nxt;
  logic [CW-1:0]        r_cnt,   w_cnt_nxt;
  logic [BW-1:0]        r_bit,   w_bit_nxt;
  logic [DATA_BITS-1:0] r_shift, w_shift_nxt;
  logic                 r_perr,  w_perr_nxt;
  logic                 r_ferr,  w_ferr_nxt;
  logic                 w_tick;
  logic                 w_done;

  logic [DATA_BITS-1:0] r_data;
  logic                 r_valid;
  logic                 r_perr_q;
  logic                 r_ferr_q;
  logic                 r_ovr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_bit   <= '0;
      r_shift <= '0;
      r_perr  <= 1'b0;
      r_ferr  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_bit   <= w_bit_nxt;
      r_shift <= w_shift_nxt;
      r_perr  <= w_perr_nxt;
      r_ferr  <= w_ferr_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_bit_nxt   = r_bit;
    w_shift_nxt = r_shift;
    w_perr_nxt  = r_perr;
    w_ferr_nxt  = r_ferr;
    w_done      = 1'b0;
    w_tick      = (r_cnt == CNT_LAST);
    case (r_state)
      IDLE: begin
        w_cnt_nxt = '0;
        w_bit_nxt = '0;
        if (!w_rxs) begin
          w_state_nxt = START;
          w_perr_nxt  = 1'b0;
          w_ferr_nxt  = 1'b0;
        end
      end
      START: begin
        // Re-check the line at mid start bit so short glitches are ignored.
        if (r_cnt == CNT_HALF) begin
          w_cnt_nxt   = '0;
          w_state_nxt = w_rxs ? IDLE : DATA;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      DATA: begin
        if (w_tick) begin
          w_cnt_nxt   = '0;
          w_shift_nxt = {w_rxs, r_shift[DATA_BITS-1:1]};
          if (r_bit == BIT_LAST) begin
            w_bit_nxt   = '0;
            w_state_nxt = (PARITY != PAR_NONE) ? PAR : STOP;
          end else begin
            w_bit_nxt = r_bit + 1'b1;
          end
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      PAR: begin
        if (w_tick) begin
          w_cnt_nxt   = '0;
          w_perr_nxt  = ((^r_shift) ^ w_rxs) != (PARITY == PAR_ODD);
          w_state_nxt = STOP;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      STOP: begin
        if (w_tick) begin
          w_cnt_nxt = '0;
          if (!w_rxs) w_ferr_nxt = 1'b1;
          if (r_bit == STOP_LAST) begin
            w_bit_nxt   = '0;
            w_state_nxt = IDLE;
            w_done      = 1'b1;
          end else begin
            w_bit_nxt = r_bit + 1'b1;
          end
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // A finished frame loads the holding register unless an unaccepted word is still held.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_data   <= '0;
      r_valid  <= 1'b0;
      r_perr_q <= 1'b0;
      r_ferr_q <= 1'b0;
      r_ovr    <= 1'b0;
    end else begin
      r_ovr <= 1'b0;
      if (w_done) begin
        if (!r_valid || ready) begin
          r_data   <= r_shift;
          r_perr_q <= r_perr;
          r_ferr_q <= w_ferr_nxt;
          r_valid  <= 1'b1;
        end else begin
          r_ovr <= 1'b1;
        end
      end else if (r_valid && ready) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign data_out   = r_data;
  assign valid      = r_valid;
  assign parity_err = r_perr_q;
  assign frame_err  = r_ferr_q;
  assign overrun    = r_ovr;
  assign busy       = (r_state != IDLE);

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Directed bench for uart_rx_cfg: 8N1, even-parity and two-stop-bit instances.
module tb_uart_rx_cfg;

  localparam int CPB = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rx0 = 1'b1, rx1 = 1'b1, rx2 = 1'b1;
  logic rdy0 = 1'b0, rdy1 = 1'b0, rdy2 = 1'b0;

  logic [7:0] d0, d1, d2;
  logic v0, v1, v2, busy0, busy1, busy2;
  logic pe0, pe1, pe2, fe0, fe1, fe2, ov0, ov1, ov2;

  uart_rx_cfg u_d0 (
    .clk(clk), .rst(rst), .rx(rx0), .data_out(d0), .valid(v0), .ready(rdy0),
    .busy(busy0), .parity_err(pe0), .frame_err(fe0), .overrun(ov0)
  );

  uart_rx_cfg #(.PARITY(1)) u_d1 (
    .clk(clk), .rst(rst), .rx(rx1), .data_out(d1), .valid(v1), .ready(rdy1),
    .busy(busy1), .parity_err(pe1), .frame_err(fe1), .overrun(ov1)
  );

  uart_rx_cfg #(.STOP_BITS(2)) u_d2 (
    .clk(clk), .rst(rst), .rx(rx2), .data_out(d2), .valid(v2), .ready(rdy2),
    .busy(busy2), .parity_err(pe2), .frame_err(fe2), .overrun(ov2)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int last_start = 0;
  int rise0 = 0;
  int rise_cyc0 = 0;
  int ovr0 = 0;
  logic v0_q = 1'b0;
  logic [12:0] rst_snap = '1;
  logic [7:0] acc_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (v0 && !v0_q) begin
      rise0     <= rise0 + 1;
      rise_cyc0 <= cyc;
    end
    v0_q <= v0;
    if (ov0) ovr0 <= ovr0 + 1;
    if (v0 && rdy0) acc_q.push_back(d0);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic drive(input int sel, input logic v);
    case (sel)
      0: rx0 = v;
      1: rx1 = v;
      default: rx2 = v;
    endcase
  endtask

  // Drives one frame; leaves the line at the last stop value so frames can run back-to-back.
  task automatic send(input int sel, input logic [7:0] data, input int np, input logic pbit,
                      input int ns, input logic [1:0] stopv, input int rst_at);
    logic [15:0] bits;
    int n;
    bits = '0;
    bits[0] = 1'b0;
    n = 1;
    for (int i = 0; i < 8; i++) begin
      bits[n] = data[i];
      n++;
    end
    if (np != 0) begin
      bits[n] = pbit;
      n++;
    end
    for (int i = 0; i < ns; i++) begin
      bits[n] = stopv[i];
      n++;
    end
    for (int b = 0; b < n; b++) begin
      for (int c = 0; c < CPB; c++) begin
        @(negedge clk);
        if (b == 0 && c == 0) last_start = cyc;
        drive(sel, bits[b]);
        if (rst_at >= 0) begin
          if (b * CPB + c == rst_at)     rst = 1'b1;
          if (b * CPB + c == rst_at + 2) rst_snap = {v0, busy0, pe0, fe0, ov0, d0};
          if (b * CPB + c == rst_at + 3) rst = 1'b0;
        end
      end
    end
  endtask

  task automatic idle(input int sel, input int n);
    @(negedge clk);
    drive(sel, 1'b1);
    repeat (n) @(negedge clk);
  endtask

  task automatic accept(input int sel);
    @(negedge clk);
    case (sel)
      0: rdy0 = 1'b1;
      1: rdy1 = 1'b1;
      default: rdy2 = 1'b1;
    endcase
    @(negedge clk);
    rdy0 = 1'b0;
    rdy1 = 1'b0;
    rdy2 = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    int r;
    int o;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_valid", v0, 0);
    chk("rst_data", d0, 0);
    chk("rst_busy", busy0, 0);
    chk("rst_flags", {pe0, fe0, ov0}, 0);
    chk("rst_valid_par", v1, 0);
    chk("rst_valid_2stop", v2, 0);

    // 8N1 0xA5, latency from start-bit drive to valid rise
    send(0, 8'hA5, 0, 1'b0, 1, 2'b11, -1);
    idle(0, 20);
    chk("a5_data", d0, 8'hA5);
    chk("a5_valid", v0, 1);
    chk("a5_flags", {pe0, fe0}, 0);
    chk("a5_latency", rise_cyc0 - last_start, 155);
    chk("a5_busy_idle", busy0, 0);
    accept(0);
    chk("a5_valid_drop", v0, 0);

    // Start glitch: line low 5 cycles
    r = rise0;
    @(negedge clk);
    rx0 = 1'b0;
    repeat (4) @(negedge clk);
    chk("glitch_busy", busy0, 1);
    @(negedge clk);
    rx0 = 1'b1;
    repeat (7) @(negedge clk);
    chk("glitch_busy_clr", busy0, 0);
    repeat (20) @(negedge clk);
    chk("glitch_no_valid", rise0, r);

    // Overrun: two frames with ready low
    o = ovr0;
    send(0, 8'h11, 0, 1'b0, 1, 2'b11, -1);
    send(0, 8'h22, 0, 1'b0, 1, 2'b11, -1);
    idle(0, 30);
    chk("ovr_data", d0, 8'h11);
    chk("ovr_valid", v0, 1);
    chk("ovr_pulses", ovr0 - o, 1);
    accept(0);
    chk("ovr_valid_drop", v0, 0);

    // Back-to-back with ready held high
    acc_q.delete();
    rdy0 = 1'b1;
    send(0, 8'h33, 0, 1'b0, 1, 2'b11, -1);
    send(0, 8'h44, 0, 1'b0, 1, 2'b11, -1);
    idle(0, 30);
    rdy0 = 1'b0;
    chk("b2b_count", acc_q.size(), 2);
    if (acc_q.size() == 2) begin
      chk("b2b_w0", acc_q[0], 8'h33);
      chk("b2b_w1", acc_q[1], 8'h44);
    end

    // Stop bit low
    send(0, 8'h7E, 0, 1'b0, 1, 2'b00, -1);
    idle(0, 30);
    chk("ferr_data", d0, 8'h7E);
    chk("ferr_flag", fe0, 1);
    chk("ferr_perr", pe0, 0);
    chk("ferr_valid", v0, 1);
    accept(0);

    // Even parity
    send(1, 8'h03, 1, 1'b1, 1, 2'b11, -1);
    idle(1, 20);
    chk("par_03_p1_data", d1, 8'h03);
    chk("par_03_p1_err", pe1, 1);
    chk("par_03_p1_ferr", fe1, 0);
    accept(1);
    send(1, 8'h03, 1, 1'b0, 1, 2'b11, -1);
    idle(1, 20);
    chk("par_03_p0_err", pe1, 0);
    chk("par_03_p0_valid", v1, 1);
    accept(1);
    send(1, 8'h07, 1, 1'b1, 1, 2'b11, -1);
    idle(1, 20);
    chk("par_07_p1_data", d1, 8'h07);
    chk("par_07_p1_err", pe1, 0);
    accept(1);

    // Two stop bits
    send(2, 8'h5A, 0, 1'b0, 2, 2'b11, -1);
    idle(2, 20);
    chk("stop2_ok_data", d2, 8'h5A);
    chk("stop2_ok_ferr", fe2, 0);
    accept(2);
    send(2, 8'hC3, 0, 1'b0, 2, 2'b01, -1);
    idle(2, 30);
    chk("stop2_bad_data", d2, 8'hC3);
    chk("stop2_bad_ferr", fe2, 1);
    chk("stop2_bad_valid", v2, 1);
    accept(2);

    // Reset during data bit 4 of 0xFF, then a clean frame
    r = rise0;
    send(0, 8'hFF, 0, 1'b0, 1, 2'b11, 5 * CPB + 4);
    idle(0, 30);
    chk("rst_mid_outputs", rst_snap, 0);
    chk("rst_mid_no_valid", rise0, r);
    chk("rst_mid_busy", busy0, 0);
    send(0, 8'h5A, 0, 1'b0, 1, 2'b11, -1);
    idle(0, 20);
    chk("post_rst_data", d0, 8'h5A);
    chk("post_rst_valid", v0, 1);
    chk("post_rst_flags", {pe0, fe0}, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
